// File: rtl/monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : monitor_pkg
// Description : Shared constants for the AGC monitor instruction trace:
//               FIFO geometry, trace entry field offsets, MSQ bit order and
//               an entry packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package monitor_pkg;

    localparam int TRACE_DEPTH = 64;
    localparam int TRACE_W     = 32;

    // Trace entry layout, LSB offsets and widths (bits 31..0):
    // {fb[4:0], eb[2:0], s[11:0], msq[6:0], seq[4:0]}
    localparam int SEQ_LSB = 0;
    localparam int SEQ_W   = 5;
    localparam int MSQ_LSB = 5;
    localparam int MSQ_W   = 7;
    localparam int S_LSB   = 12;
    localparam int S_W     = 12;
    localparam int EB_LSB  = 24;
    localparam int EB_W    = 3;
    localparam int FB_LSB  = 27;
    localparam int FB_W    = 5;

    // Bit positions inside the MSQ bus
    localparam int MSQ10_BIT  = 0;
    localparam int MSQ11_BIT  = 1;
    localparam int MSQ12_BIT  = 2;
    localparam int MSQ13_BIT  = 3;
    localparam int MSQ14_BIT  = 4;
    localparam int MSQ16_BIT  = 5;
    localparam int MSQEXT_BIT = 6;

    function automatic logic [TRACE_W-1:0] pack_entry(
        input logic [FB_W-1:0]  fb,
        input logic [EB_W-1:0]  eb,
        input logic [S_W-1:0]   s,
        input logic [MSQ_W-1:0] msq,
        input logic [SEQ_W-1:0] seq
    );
        logic [TRACE_W-1:0] e;
        e = '0;
        e[FB_LSB  +: FB_W]  = fb;
        e[EB_LSB  +: EB_W]  = eb;
        e[S_LSB   +: S_W]   = s;
        e[MSQ_LSB +: MSQ_W] = msq;
        e[SEQ_LSB +: SEQ_W] = seq;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Synchronous FIFO with registered read port.
//   clk, rst_n     : clock, asynchronous active-low reset (pointers only)
//   flush          : synchronous empty; overrides same-cycle push/pop
//   push/push_data : write request and data; dropped when full unless a pop
//                    is accepted in the same cycle
//   pop            : read request; ignored when empty
//   rd_data        : oldest entry, one cycle after an accepted pop (held)
//   rd_valid       : rd_data was updated by a pop in the previous cycle
//   count/full/empty : occupancy, derived from registered pointers only
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (count == DEPTH_CNT);

    assign do_pop  = pop  & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop) & ~flush;

    // Storage has no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + 1'b1;
                end
                if (do_pop) begin
                    rptr    <= rptr + 1'b1;
                    rd_data <= mem[rptr[AW-1:0]];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/monitor_trace.sv
`default_nettype none
// ============================================================================
// Module      : monitor_trace
// Description : Instruction trace capture for the AGC monitor. Shadows the
//               S register and bank registers from the write bus, and on each
//               new instruction (MNISQ rising edge) records a 32-bit entry
//               {fb, eb, s, MSQ, seq} into a 64-entry FIFO.
//   SIM_CLK, SIM_RST_N        : clock, asynchronous active-low reset
//   MWL, MWSG/MWBBEG/MWEBG/MWFBG : write bus and register write strobes
//   MSQ, MNISQ, MSTP          : sequence register, new-instruction, stop
//   trace_en, freeze_on_stop  : capture qualifiers
//   clear                     : synchronous flush of FIFO, seq and flags
//   rd_req, rd_data, rd_valid : pop interface, one-cycle read latency
//   count, empty              : FIFO occupancy
//   overflow, drop_cnt        : sticky drop flag, saturating drop counter
// Revision    : 1.0 - initial release
// ============================================================================
module monitor_trace
    import monitor_pkg::*;
(
    input  logic        SIM_CLK,
    input  logic        SIM_RST_N,
    input  logic [15:0] MWL,
    input  logic        MWSG,
    input  logic        MWBBEG,
    input  logic        MWEBG,
    input  logic        MWFBG,
    input  logic [6:0]  MSQ,
    input  logic        MNISQ,
    input  logic        MSTP,
    input  logic        trace_en,
    input  logic        freeze_on_stop,
    input  logic        clear,
    input  logic        rd_req,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [6:0]  count,
    output logic        empty,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    logic [S_W-1:0]     s;
    logic [FB_W-1:0]    fb;
    logic [EB_W-1:0]    eb;
    logic [SEQ_W-1:0]   seq;
    logic               mnisq_q;
    logic               nisq_event;
    logic               capture_ok;
    logic               push;
    logic               pop;
    logic               full;
    logic               drop;
    logic [TRACE_W-1:0] entry;
    logic               unused_mwl15;

    // MWL01..MWL15 carry data; bit 15 is the parity/sign position and is
    // not part of any shadowed register.
    assign unused_mwl15 = MWL[15];

    assign nisq_event = MNISQ & ~mnisq_q;
    assign capture_ok = trace_en & ~(freeze_on_stop & MSTP);
    assign push       = nisq_event & capture_ok & ~clear;
    assign pop        = rd_req & ~empty & ~clear;
    assign drop       = push & full & ~pop;

    // Built from the current shadow registers, so a strobe in the same cycle
    // as the event only affects later entries.
    assign entry = pack_entry(fb, eb, s, MSQ, seq);

    // Shadow registers and edge detector survive clear; only reset zeroes them.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_N) begin
        if (!SIM_RST_N) begin
            s       <= '0;
            fb      <= '0;
            eb      <= '0;
            mnisq_q <= 1'b0;
        end else begin
            mnisq_q <= MNISQ;
            if (MWSG) begin
                s <= MWL[11:0];
            end
            // BB carries both bank fields; FB/EB strobes update one each.
            if (MWBBEG) begin
                fb <= MWL[14:10];
                eb <= MWL[2:0];
            end else begin
                if (MWFBG) begin
                    fb <= MWL[14:10];
                end
                if (MWEBG) begin
                    eb <= MWL[10:8];
                end
            end
        end
    end

    // Sequence number advances on every detected event, captured or not.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_N) begin
        if (!SIM_RST_N) begin
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (nisq_event) begin
                seq <= seq + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk       (SIM_CLK),
        .rst_n     (SIM_RST_N),
        .flush     (clear),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_monitor_trace.sv
`default_nettype none
// ============================================================================
// Module      : tb_monitor_trace
// Description : Scoreboard testbench for monitor_trace. Stimulus pushes the
//               expected entries into a queue; a monitor compares every
//               rd_valid beat against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monitor_trace;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST_N;
    logic [15:0] MWL;
    logic        MWSG, MWBBEG, MWEBG, MWFBG;
    logic [6:0]  MSQ;
    logic        MNISQ, MSTP, trace_en, freeze_on_stop, clear, rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [6:0]  count;
    logic        empty, overflow;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int          m_count;
    int          m_seq;
    logic [11:0] m_s;
    logic [4:0]  m_fb;
    logic [2:0]  m_eb;

    monitor_trace dut (
        .SIM_CLK        (SIM_CLK),
        .SIM_RST_N      (SIM_RST_N),
        .MWL            (MWL),
        .MWSG           (MWSG),
        .MWBBEG         (MWBBEG),
        .MWEBG          (MWEBG),
        .MWFBG          (MWFBG),
        .MSQ            (MSQ),
        .MNISQ          (MNISQ),
        .MSTP           (MSTP),
        .trace_en       (trace_en),
        .freeze_on_stop (freeze_on_stop),
        .clear          (clear),
        .rd_req         (rd_req),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .count          (count),
        .empty          (empty),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    function automatic logic [31:0] mk_entry(input logic [4:0] fb, input logic [2:0] eb,
                                             input logic [11:0] s, input logic [6:0] msq,
                                             input int seq);
        logic [4:0] sq;
        sq = seq[4:0];
        return {fb, eb, s, msq, sq};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    // One MNISQ pulse; the expected entry is queued when capture is allowed
    // and the model FIFO has room.
    task automatic do_event(input bit allowed);
        MNISQ = 1'b1;
        if (allowed) begin
            if (m_count < 64) begin
                exp_q.push_back(mk_entry(m_fb, m_eb, m_s, MSQ, m_seq));
                m_count++;
            end
        end
        m_seq++;
        tick();
        MNISQ = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        if (m_count > 0) m_count--;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_seq   = 0;
    endtask

    // Monitor: every valid read beat must match the oldest expected entry.
    always @(negedge SIM_CLK) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got 0x%0h expected no data", rd_data);
            end else begin
                check("pop_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        SIM_RST_N = 1'b0;
        MWL = '0; MWSG = 0; MWBBEG = 0; MWEBG = 0; MWFBG = 0;
        MSQ = '0; MNISQ = 0; MSTP = 0; trace_en = 0; freeze_on_stop = 0;
        clear = 0; rd_req = 0;
        m_count = 0; m_seq = 0; m_s = '0; m_fb = '0; m_eb = '0;

        // Reset values
        #3;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_count", {25'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        tick();
        SIM_RST_N = 1'b1;
        tick();
        trace_en = 1'b1;

        // S and FB shadows, MNISQ held five cycles -> one entry
        MWSG = 1'b1; MWL = 16'o2345; tick(); MWSG = 1'b0; m_s = 12'o2345;
        MWFBG = 1'b1; MWL = 16'o36000; tick(); MWFBG = 1'b0; m_fb = 5'o17;
        MSQ = 7'h55;
        MNISQ = 1'b1;
        exp_q.push_back(mk_entry(m_fb, m_eb, m_s, MSQ, m_seq));
        m_count++; m_seq++;
        repeat (5) tick();
        MNISQ = 1'b0;
        tick();
        check("held_mnisq_count", {25'd0, count}, 32'd1);
        pop_one();
        tick();

        // BB/EB shadows, then an S write in the same cycle as the event
        MWBBEG = 1'b1; MWL = 16'b0101_0100_0000_0110; tick(); MWBBEG = 1'b0;
        m_fb = 5'b10101; m_eb = 3'b110;
        MWEBG = 1'b1; MWL = 16'h0300; tick(); MWEBG = 1'b0; m_eb = 3'b011;
        MSQ = 7'h2A;
        MWSG = 1'b1; MWL = 16'o7777;
        do_event(1'b1);
        MWSG = 1'b0; m_s = 12'o7777;
        pop_one();
        tick();

        // Overflow: 70 events, no reads
        do_clear();
        check("clr_count", {25'd0, count}, 32'd0);
        check("clr_empty", {31'd0, empty}, 32'd1);
        MSQ = 7'h11;
        for (int i = 0; i < 70; i++) do_event(1'b1);
        check("full_count", {25'd0, count}, 32'd64);
        check("full_overflow", {31'd0, overflow}, 32'd1);
        check("full_drop_cnt", {24'd0, drop_cnt}, 32'd6);

        // Push and pop together while full
        MNISQ = 1'b1; rd_req = 1'b1;
        exp_q.push_back(mk_entry(m_fb, m_eb, m_s, MSQ, m_seq));
        m_seq++;
        tick();
        MNISQ = 1'b0; rd_req = 1'b0;
        check("full_pushpop_count", {25'd0, count}, 32'd64);
        check("full_pushpop_drop", {24'd0, drop_cnt}, 32'd6);
        tick();
        for (int i = 0; i < 64; i++) pop_one();
        tick();
        check("drained_empty", {31'd0, empty}, 32'd1);
        check("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Freeze on stop: three suppressed events, then one captured
        do_clear();
        freeze_on_stop = 1'b1; MSTP = 1'b1;
        for (int i = 0; i < 3; i++) do_event(1'b0);
        check("frozen_count", {25'd0, count}, 32'd0);
        MSTP = 1'b0;
        do_event(1'b1);
        check("unfrozen_count", {25'd0, count}, 32'd1);
        pop_one();
        freeze_on_stop = 1'b0;
        tick();

        // Push and pop together while empty
        MNISQ = 1'b1; rd_req = 1'b1;
        exp_q.push_back(mk_entry(m_fb, m_eb, m_s, MSQ, m_seq));
        m_count++; m_seq++;
        tick();
        MNISQ = 1'b0; rd_req = 1'b0;
        check("empty_pushpop_valid", {31'd0, rd_valid}, 32'd0);
        check("empty_pushpop_count", {25'd0, count}, 32'd1);
        tick();
        pop_one();
        tick();

        // Clear with a simultaneous event and read
        do_event(1'b1);
        do_event(1'b1);
        clear = 1'b1; MNISQ = 1'b1; rd_req = 1'b1;
        tick();
        exp_q.delete(); m_count = 0; m_seq = 0;
        check("clear_count", {25'd0, count}, 32'd0);
        check("clear_valid", {31'd0, rd_valid}, 32'd0);
        clear = 1'b0; MNISQ = 1'b0; rd_req = 1'b0;
        tick();
        do_event(1'b1);
        pop_one();
        tick();

        // trace_en low suppresses capture but still consumes a seq value
        trace_en = 1'b0;
        do_event(1'b0);
        trace_en = 1'b1;
        do_event(1'b1);
        pop_one();
        tick();

        // Asynchronous reset with ten entries and a read pending
        for (int i = 0; i < 10; i++) do_event(1'b1);
        check("pre_reset_count", {25'd0, count}, 32'd10);
        rd_req = 1'b1;
        #2;
        SIM_RST_N = 1'b0;
        #1;
        exp_q.delete(); m_count = 0; m_seq = 0;
        m_s = '0; m_fb = '0; m_eb = '0;
        check("async_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("async_rd_data", rd_data, 32'd0);
        check("async_count", {25'd0, count}, 32'd0);
        check("async_empty", {31'd0, empty}, 32'd1);
        check("async_overflow", {31'd0, overflow}, 32'd0);
        check("async_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        tick();
        tick();
        SIM_RST_N = 1'b1;
        tick();
        check("post_reset_valid", {31'd0, rd_valid}, 32'd0);
        check("post_reset_count", {25'd0, count}, 32'd0);
        rd_req = 1'b0;
        tick();
        do_event(1'b1);
        pop_one();
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
